// File: rtl/spi_pkg.sv
// Shared SPI register-interface definitions.
// Used by the SPI controller (spi_reg_controller) and by the SPI register
// peripheral. It holds the frame layout, the peripheral register map, the
// controller state encoding and a frame-packing helper.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;

  // Frame field positions (MSB is shifted out first)
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Peripheral register map
  localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
  localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
  localparam logic [6:0] REG_PWM_EN_LO = 7'h02;
  localparam logic [6:0] REG_PWM_EN_HI = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY  = 7'h04;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } ctrl_state_t;

  // Pack request fields into a transmit frame
  function automatic logic [SPI_FRAME_W-1:0] build_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] data
  );
    logic [SPI_FRAME_W-1:0] f;
    f                    = {SPI_FRAME_W{1'b0}};
    f[RW_BIT]            = rw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_reg_controller_if.sv
// Request handshake plus SPI pin bundle for spi_reg_controller.
//   master : requester side. It drives req_valid/req_rw/req_addr/req_data
//            and observes req_ready, done and the SPI pins.
//   slave  : controller side. It receives the request and drives
//            req_ready, done, sclk, ncs and copi.
interface spi_reg_controller_if;
  import spi_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_rw;
  logic [ADDR_MSB-ADDR_LSB:0] req_addr;
  logic [DATA_MSB-DATA_LSB:0] req_data;
  logic                     done;
  logic                     sclk;
  logic                     ncs;
  logic                     copi;

  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, done, sclk, ncs, copi
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, done, sclk, ncs, copi
  );
endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter used to time each controller phase.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val and arm the timer (takes priority)
//   load_val  : phase length minus one
//   expire    : high for one cycle once the loaded count has run out
// A load of N produces expire N cycles after the loading edge. That makes a
// phase exactly N+1 cycles long when the next load happens on that expire.
module spi_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_r;
  logic         armed_r;

  // Count down after a load; disarm once the terminal count has been reported
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {W{1'b0}};
      armed_r <= 1'b0;
    end else if (load) begin
      cnt_r   <= load_val;
      armed_r <= 1'b1;
    end else if (armed_r) begin
      if (cnt_r == {W{1'b0}}) begin
        armed_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - W'(1'b1);
      end
    end
  end

  assign expire = armed_r && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 controller that sends one 16-bit register frame per request.
// Ports:
//   clk, rst : system clock and synchronous active-high reset
//   bus      : slave side of spi_reg_controller_if. It carries the
//              req_valid/req_ready handshake, the request fields
//              {req_rw, req_addr, req_data}, the done pulse and the SPI pins
//              sclk/ncs/copi.
// Parameters:
//   CLK_DIV : clk cycles per SCLK half-period (>= 3)
//   CS_GAP  : clk cycles ncs stays high after a frame before done (>= 1)
// Frame: ncs falls on accept. There are 16 LOW/HIGH bit periods, MSB first,
// with copi updated only when a LOW phase begins. A HOLD phase keeps ncs low
// after the last falling edge, and then ncs is high for the GAP phase.
// done and req_ready both rise when the GAP phase ends.
module spi_reg_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic clk,
  input  logic rst,
  spi_reg_controller_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP);
  localparam int CNT_W = (DIV_W > GAP_W) ? DIV_W : GAP_W;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_GAP - 1);

  ctrl_state_t            state_r;
  logic [SPI_FRAME_W-1:0] shift_r;
  logic [3:0]             bit_cnt_r;
  logic                   sclk_r;
  logic                   ncs_r;
  logic                   copi_r;
  logic                   done_r;
  logic                   ready_r;

  logic                   load_s;
  logic [CNT_W-1:0]       load_val_s;
  logic                   expire_s;
  logic                   accept_s;

  assign accept_s = bus.req_valid && ready_r;

  spi_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .expire   (expire_s)
  );

  // Reload the phase timer on every state entry; only GAP uses CS_GAP
  always_comb begin
    load_s     = 1'b0;
    load_val_s = DIV_LOAD;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) load_s = 1'b1;
        else          load_s = 1'b0;
      end
      ST_LOW, ST_HIGH: begin
        if (expire_s) load_s = 1'b1;
        else          load_s = 1'b0;
      end
      ST_HOLD: begin
        if (expire_s) begin
          load_s     = 1'b1;
          load_val_s = GAP_LOAD;
        end else begin
          load_s     = 1'b0;
        end
      end
      ST_GAP:  load_s = 1'b0;
      default: load_s = 1'b0;
    endcase
  end

  // Frame sequencer with registered SPI pins, done and req_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {SPI_FRAME_W{1'b0}};
      bit_cnt_r <= 4'd0;
      sclk_r    <= 1'b0;
      ncs_r     <= 1'b1;
      copi_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shift_r   <= build_frame(bus.req_rw, bus.req_addr, bus.req_data);
            bit_cnt_r <= 4'd0;
            ncs_r     <= 1'b0;
            copi_r    <= bus.req_rw;
            ready_r   <= 1'b0;
            state_r   <= ST_LOW;
          end
        end
        ST_LOW: begin
          // copi always reflects the current MSB during LOW
          copi_r <= shift_r[SPI_FRAME_W-1];
          if (expire_s) begin
            sclk_r  <= 1'b1;
            state_r <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (expire_s) begin
            sclk_r <= 1'b0;
            if (bit_cnt_r == 4'd15) begin
              state_r <= ST_HOLD;
            end else begin
              // Next bit goes out together with the SCLK falling edge
              shift_r   <= {shift_r[SPI_FRAME_W-2:0], 1'b0};
              copi_r    <= shift_r[SPI_FRAME_W-2];
              bit_cnt_r <= bit_cnt_r + 4'd1;
              state_r   <= ST_LOW;
            end
          end
        end
        ST_HOLD: begin
          if (expire_s) begin
            ncs_r   <= 1'b1;
            copi_r  <= 1'b0;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (expire_s) begin
            done_r  <= 1'b1;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          ncs_r   <= 1'b1;
          copi_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.done      = done_r;
  assign bus.sclk      = sclk_r;
  assign bus.ncs       = ncs_r;
  assign bus.copi      = copi_r;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench for spi_reg_controller (default CLK_DIV=4, CS_GAP=4).
// A cycle-offset model predicts every output from "cycles since accept" and
// the accepted word. A receiver rebuilds each frame from copi on sclk rises.
module tb_spi_reg_controller;
  import spi_pkg::*;

  localparam int D = 4;
  localparam int G = 4;
  localparam int FRAME_CYC = 33 * D + G;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_reg_controller_if bus();

  spi_reg_controller #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Behavioural model: k = clock edges since the accept edge (-1 = no frame)
  int          k_m    = -1;
  logic [15:0] word_m = 16'h0000;

  always @(posedge clk) begin
    if (rst) k_m <= -1;
    else if ((k_m < 0 || k_m >= FRAME_CYC) && bus.req_valid === 1'b1) begin
      k_m    <= 0;
      word_m <= {bus.req_rw, bus.req_addr, bus.req_data};
    end else if (k_m >= 0) k_m <= k_m + 1;
  end

  // Expected {ready, done, ncs, sclk, copi} at offset k
  function automatic logic [4:0] model_out(input int k, input logic [15:0] w);
    int ph;
    if (k < 0) return 5'b10100;
    ph = k / D;
    if (k < 32 * D) return {1'b0, 1'b0, 1'b0, ((ph % 2) == 1), w[15 - ph / 2]};
    if (k < 33 * D) return {1'b0, 1'b0, 1'b0, 1'b0, w[0]};
    if (k < FRAME_CYC) return 5'b00100;
    if (k == FRAME_CYC) return 5'b11100;
    return 5'b10100;
  endfunction

  task automatic check_cycle();
    logic [4:0] e;
    e = model_out(k_m, word_m);
    chk("cyc_ready", 32'(bus.req_ready), 32'(e[4]));
    chk("cyc_done",  32'(bus.done),      32'(e[3]));
    chk("cyc_ncs",   32'(bus.ncs),       32'(e[2]));
    chk("cyc_sclk",  32'(bus.sclk),      32'(e[1]));
    chk("cyc_copi",  32'(bus.copi),      32'(e[0]));
  endtask

  always @(negedge clk) begin
    if (chk_en) check_cycle();
  end

  // Receiver: rebuild frames, count sclk rises and ncs-low cycles
  typedef struct {
    logic [15:0] word;
    int          bits;
    int          low;
  } rx_t;
  rx_t         rx_q[$];
  logic [15:0] rx_word   = 16'h0000;
  int          rx_bits   = 0;
  int          rx_low    = 0;
  logic        prev_ncs  = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (bus.ncs === 1'b0) begin
      if (prev_ncs === 1'b1) begin
        rx_word <= 16'h0000;
        rx_bits <= 0;
        rx_low  <= 1;
      end else begin
        rx_low <= rx_low + 1;
        if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
          rx_word <= {rx_word[14:0], bus.copi};
          rx_bits <= rx_bits + 1;
        end
      end
    end else if (prev_ncs === 1'b0) begin
      rx_q.push_back(rx_t'{word: rx_word, bits: rx_bits, low: rx_low});
    end
    prev_ncs  <= bus.ncs;
    prev_sclk <= bus.sclk;
  end

  task automatic check_rx(input string name, input logic [15:0] w, input int bits);
    rx_t r;
    if (rx_q.size() == 0) begin
      fail_now({name, "_missing"});
      return;
    end
    r = rx_q.pop_front();
    chk({name, "_word"}, 32'(r.word), 32'(w));
    chk({name, "_bits"}, r.bits, bits);
    if (bits == 16) chk({name, "_ncs_low"}, r.low, 32 * D + D);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_sclk"},  32'(bus.sclk),      32'd0);
    chk({name, "_ncs"},   32'(bus.ncs),       32'd1);
    chk({name, "_copi"},  32'(bus.copi),      32'd0);
    chk({name, "_done"},  32'(bus.done),      32'd0);
    chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] w, input bit hold, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = w[15];
    bus.req_addr  = w[14:8];
    bus.req_data  = w[7:0];
    while (bus.req_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) fail_now("accept");
    @(negedge clk);
    acc = cyc;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // Wait for done; hi counts ncs-high cycles seen before it
  task automatic wait_done(output int dc, output int hi);
    int t;
    t  = 0;
    hi = 0;
    dc = -1;
    while (t < 400) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dc = cyc;
        break;
      end
      if (bus.ncs === 1'b1) hi++;
      t++;
    end
    if (dc < 0) fail_now("done");
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, d0, d1, hi, t, nd;
    logic [15:0] w;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_data  = 8'h00;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Reset pulse while idle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_reset");

    // Single write 0x84A5
    send({1'b1, REG_PWM_DUTY, 8'hA5}, 1'b0, a0);
    wait_done(d0, hi);
    chk("wr_latency", d0 - a0, 136);
    chk("wr_gap", hi, G);
    @(negedge clk);
    check_rx("wr", 16'h84A5, 16);

    // Read-bit frame 0x0312
    send({1'b0, REG_PWM_EN_HI, 8'h12}, 1'b0, a0);
    wait_done(d0, hi);
    chk("rd_latency", d0 - a0, 136);
    chk("rd_gap", hi, G);
    @(negedge clk);
    check_rx("rd", 16'h0312, 16);

    // Back-to-back 0x8001 then 0x81FF with req_valid held
    send({1'b1, REG_EN_OUT_LO, 8'h01}, 1'b1, a0);
    bus.req_addr = REG_EN_OUT_HI;
    bus.req_data = 8'hFF;
    wait_done(d0, hi);
    chk("b2b_ready_in_done", 32'(bus.req_ready), 32'd1);
    chk("b2b_gap", hi, G);
    @(negedge clk);
    a1 = cyc;
    chk("b2b_accept_in_done", 32'(bus.ncs), 32'd0);
    bus.req_valid = 1'b0;
    chk("b2b_period", a1 - a0, 137);
    wait_done(d1, hi);
    chk("b2b_latency2", d1 - a1, 136);
    @(negedge clk);
    check_rx("b2b0", 16'h8001, 16);
    check_rx("b2b1", 16'h81FF, 16);

    // Busy rejection: pulse 0x8333 mid-frame, then hold it until accepted
    send({1'b1, REG_EN_OUT_LO, 8'hAA}, 1'b0, a0);
    repeat (40) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = REG_PWM_EN_HI;
    bus.req_data  = 8'h33;
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    bus.req_valid = 1'b1;
    wait_done(d0, hi);
    @(negedge clk);
    a1 = cyc;
    chk("busy_accept_after_done", 32'(bus.ncs), 32'd0);
    bus.req_valid = 1'b0;
    chk("busy_period", a1 - a0, 137);
    wait_done(d1, hi);
    @(negedge clk);
    check_rx("busy_a", 16'h80AA, 16);
    check_rx("busy_b", 16'h8333, 16);

    // Reset after the 7th sclk rise of 0x84C3
    send({1'b1, REG_PWM_DUTY, 8'hC3}, 1'b0, a0);
    t = 0;
    while (rx_bits != 7 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("abort_7th_rise");
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ncs",  32'(bus.ncs),  32'd1);
    chk("abort_sclk", 32'(bus.sclk), 32'd0);
    chk("abort_copi", 32'(bus.copi), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_rx("abort", 16'h0042, 7);
    nd = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    send({1'b1, REG_PWM_EN_LO, 8'h55}, 1'b0, a0);
    wait_done(d0, hi);
    chk("after_abort_latency", d0 - a0, 136);
    @(negedge clk);
    check_rx("after_abort", 16'h8255, 16);

    // Random frames with random idle gaps
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(w, 1'b0, a0);
      wait_done(d0, hi);
      chk("rand_latency", d0 - a0, 136);
      @(negedge clk);
      check_rx("rand", w, 16);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
